// File: rtl/regfile_writeback_queue.sv
// Writeback front end for the register file: accepts ALU/load results, queues them in order,
// drains one per cycle onto the single write port, and forwards pending values to decode.
module regfile_writeback_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [ADDR_W-1:0] alu_dest_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [ADDR_W-1:0] mem_dest_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wb_stall_i,
    output logic [ADDR_W-1:0] wb_dest_o,
    output logic              wb_write_enable_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic [ADDR_W-1:0] fwd_src_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wb_we_q, wb_we_d;
    logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              full, acc_mem, acc_alu, push, pop;
    logic [ADDR_W-1:0] push_dest;
    logic [DATA_W-1:0] push_data;
    logic [PTR_W-1:0]  fwd_idx;

    always_comb begin
        full        = (count_q == CNT_W'(DEPTH));
        mem_ready_o = !full;
        // Loads win the single accept slot; ALU ready never looks at its own valid.
        alu_ready_o = !full && !mem_valid_i;
        acc_mem     = mem_valid_i && mem_ready_o;
        acc_alu     = alu_valid_i && alu_ready_o;
        push_dest   = acc_mem ? mem_dest_i : alu_dest_i;
        push_data   = acc_mem ? mem_data_i : alu_data_i;
        // x0 writes are acknowledged but never stored.
        push        = (acc_mem || acc_alu) && (push_dest != '0);
        pop         = (count_q != '0) && !wb_stall_i;

        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        wb_we_d   = pop;
        wb_dest_d = pop ? dest_q[rd_ptr_q] : wb_dest_q;
        wb_data_d = pop ? data_q[rd_ptr_q] : wb_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wb_we_q   <= wb_we_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr_q] <= push_dest;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    // Walk wb stage then FIFO oldest-to-youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = '0;
        if (fwd_src_i != '0) begin
            if (wb_we_q && (wb_dest_q == fwd_src_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = wb_data_q;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fwd_idx = rd_ptr_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (dest_q[fwd_idx] == fwd_src_i)) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = data_q[fwd_idx];
                end
            end
        end
    end

    assign wb_write_enable_o = wb_we_q;
    assign wb_dest_o         = wb_dest_q;
    assign wb_data_o         = wb_data_q;
    assign count_o           = count_q;

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
Write-side front end for the 32x32 two-read/one-write register file. Accepts writeback results from the ALU and load/store unit over valid/ready handshakes, buffers them in a small in-order FIFO, and drains one entry per cycle onto the register file's single write port (dest / write_enable / data_in). It also provides a forwarding lookup so decode can read values that are queued or in flight but not yet written.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
DATA_W, 32, register data width
ADDR_W, 5, register index width
CNT_W, log2(DEPTH)+1, width of the occupancy count

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this edge if alu_valid is high
alu_dest  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result offered
mem_ready  out  1  load result accepted this edge if mem_valid is high
mem_dest  in  ADDR_W  load destination register
mem_data  in  DATA_W  load result
wb_stall  in  1  write port unavailable; hold the queue
wb_dest  out  ADDR_W  to register file dest
wb_write_enable  out  1  to register file write_enable
wb_data  out  DATA_W  to register file data_in
fwd_src  in  ADDR_W  register index to look up
fwd_hit  out  1  a pending write to fwd_src exists
fwd_data  out  DATA_W  youngest pending value for fwd_src
count  out  CNT_W  FIFO occupancy (excludes the wb stage)

Behaviour:
- Reset (async assert, sync release): pointers=0, count=0, wb_write_enable=0, wb_dest=0, wb_data=0.
  - All queued entries are discarded, including on reset mid-operation.
  - After reset, alu_ready=1 and mem_ready=1.
- Handshake: a transfer occurs at an edge when valid && ready. Producers hold valid/dest/data stable until accepted.
  - Ready signals are combinational and do not depend on the same port's valid.
- Enqueue is at most one per cycle, with fixed load priority:
  - mem_ready = (count != DEPTH).
  - alu_ready = (count != DEPTH) && !mem_valid.
- Full is evaluated on the current count. There is no push-into-popping-slot bypass: when count==DEPTH both readies are 0, even if a pop occurs that edge.
- Writes to x0 are handshaken normally, then dropped: no entry, count unchanged, no wb pulse. x0 writes still consume that cycle's accept slot.
- Drain: at each edge where count>0 && !wb_stall, the head is popped into the wb registers and wb_write_enable=1 for the following cycle. Otherwise wb_write_enable=0 next cycle.
  - wb_dest and wb_data hold their last value when not writing.
- Latency: entry accepted at edge t with empty FIFO and no stall → wb_write_enable high after edge t+1 → register file writes at edge t+2.
- Ordering is strictly FIFO. Back-to-back pops give continuous one-cycle pulses.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Forwarding is combinational:
  - It searches valid FIFO entries youngest to oldest, then the wb stage (only when wb_write_enable=1).
  - The first match gives fwd_hit=1 and fwd_data equal to that entry's data.
  - fwd_src==0 or no match gives fwd_hit=0 and fwd_data=0.
  - An entry accepted at the current edge is visible to the lookup from the next cycle.
- wb_stall asserted while wb_write_enable=1 does not cancel the pulse already presented; it only blocks the next pop.

Test Plan:
1. Reset; ALU push x5=0xDEADBEEF, no stall → count 1 after edge t, 0 after t+1; wb_write_enable high one cycle with wb_dest=5, wb_data=0xDEADBEEF.
2. mem x3=0x11 and alu x4=0x22 valid in the same cycle → alu_ready=0 in cycle 1, mem accepted; alu accepted in cycle 2; wb pulses x3 then x4 on consecutive cycles.
3. wb_stall=1, push x1..x4 (0x1..0x4) → count=4, both readies 0; 5th push (x6) held. Release stall → writes x1,x2,x3,x4,x6 in order, one per cycle; x6 accepted at the edge after the first pop.
4. wb_stall=1, push x7=0xA then x7=0xB → fwd_src=7 gives hit=1, data=0xB. fwd_src=0 gives hit=0, data=0. fwd_src=8 gives hit=0, data=0. Release stall, and in the cycle wb shows x7=0xB (FIFO empty), fwd_src=7 gives hit=1, data=0xB.
5. ALU push x0=0xFFFF → alu_ready=1, accepted; count stays 0; no wb_write_enable pulse.
6. Three entries queued with a stall, then drop rst_n mid-cycle → count=0, wb_write_enable=0, wb_dest=0 immediately, readies=1; after release and de-stall, no wb pulses occur.
